// File: rtl/hh_pkg.sv
// Types and helpers shared by the Hodgkin-Huxley neuron core and its downstream stages.
package hh_pkg;

  localparam int HH_TS_W = 16;

  typedef struct packed {
    logic                 first;
    logic [HH_TS_W-1:0]   isi;
  } hh_evt_t;

  // Saturating increment on a 32-bit carrier; callers truncate to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hh_evt_fifo.sv
// First-word-fall-through event FIFO with occupancy output; push while full is accepted only alongside a pop.
module hh_evt_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  output logic                     full,
  input  logic                     pop,
  output T                         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (level_q == (PTR_W+1)'(DEPTH));
    empty    = (level_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
    pop_data = mem_q[rd_ptr_q];
    level    = level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hh_spike_monitor.sv
// Turns neuron spikes into inter-spike-interval events on a buffered valid/ready stream,
// and publishes a per-window spike rate and a count of events lost to a full FIFO.
module hh_spike_monitor
  import hh_pkg::*;
#(
  parameter int TS_W       = HH_TS_W,
  parameter int WIN_CYC    = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    spike_in,
  input  logic                          en,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [TS_W-1:0]               evt_isi,
  output logic                          evt_first,
  output logic [7:0]                    rate,
  output logic                          rate_valid,
  output logic [7:0]                    drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int          WIN_W   = $clog2(WIN_CYC);
  localparam logic [31:0] ISI_MAX = 32'((64'd1 << TS_W) - 64'd1);

  typedef struct packed {
    logic            first;
    logic [TS_W-1:0] isi;
  } evt_t;

  logic             spike_q, spike_d;
  logic [TS_W-1:0]  isi_cnt_q, isi_cnt_d;
  logic             first_flag_q, first_flag_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       rate_q, rate_d;
  logic             rate_valid_q, rate_valid_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic spike_now, spike_edge, win_last, pop_fire;
  logic fifo_full, fifo_empty;
  evt_t push_evt, head_evt;

  always_comb begin
    spike_now  = (spike_in != '0);
    spike_edge = spike_now && !spike_q && en;
    win_last   = (win_cnt_q == WIN_W'(WIN_CYC - 1));
    pop_fire   = !fifo_empty && evt_ready;

    spike_d        = spike_now;
    isi_cnt_d      = isi_cnt_q;
    first_flag_d   = first_flag_q;
    win_cnt_d      = win_cnt_q;
    acc_d          = acc_q;
    rate_d         = rate_q;
    rate_valid_d   = 1'b0;
    drop_cnt_d     = drop_cnt_q;
    push_evt.first = first_flag_q;
    push_evt.isi   = isi_cnt_q;

    if (spike_edge) begin
      isi_cnt_d    = TS_W'(1);
      first_flag_d = 1'b0;
    end else if (en) begin
      isi_cnt_d = TS_W'(sat_inc(32'(isi_cnt_q), ISI_MAX));
    end

    // An edge on the last window cycle is folded into the closing window's rate.
    if (en) begin
      win_cnt_d = win_last ? '0 : win_cnt_q + WIN_W'(1);
      if (win_last) begin
        rate_d       = spike_edge ? 8'(sat_inc(32'(acc_q), 32'd255)) : acc_q;
        rate_valid_d = 1'b1;
        acc_d        = '0;
      end else if (spike_edge) begin
        acc_d = 8'(sat_inc(32'(acc_q), 32'd255));
      end
    end

    if (spike_edge && fifo_full && !pop_fire)
      drop_cnt_d = 8'(sat_inc(32'(drop_cnt_q), 32'd255));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_q      <= 1'b0;
      isi_cnt_q    <= '0;
      first_flag_q <= 1'b1;
      win_cnt_q    <= '0;
      acc_q        <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      spike_q      <= spike_d;
      isi_cnt_q    <= isi_cnt_d;
      first_flag_q <= first_flag_d;
      win_cnt_q    <= win_cnt_d;
      acc_q        <= acc_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  hh_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (spike_edge),
    .push_data (push_evt),
    .full      (fifo_full),
    .pop       (evt_ready),
    .pop_data  (head_evt),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    evt_valid  = !fifo_empty;
    evt_isi    = head_evt.isi;
    evt_first  = head_evt.first;
    rate       = rate_q;
    rate_valid = rate_valid_q;
    drop_cnt   = drop_cnt_q;
  end

endmodule

// File: doc/hh_spike_monitor.md
# hh_spike_monitor

Downstream stage of the Hodgkin-Huxley neuron core. It consumes the neuron's `spike` output and turns spikes into inter-spike-interval (ISI) events on a valid/ready stream, buffered in a small FIFO. It also publishes a saturating per-window spike rate and a drop counter. It sits between the neuron core and the readout/IO logic.

## Interface
Parameters:
- `TS_W`, 16: ISI counter and event width, in bits.
- `WIN_CYC`, 256: rate window length in clock cycles, ≥2.
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of 2, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `spike_in`  in  8  neuron spike word; any nonzero value means spike asserted.
- `en`  in  1  monitoring enable.
- `evt_valid`  out  1  FIFO head valid.
- `evt_ready`  in  1  consumer accepts head.
- `evt_isi`  out  TS_W  ISI of the head event, in cycles.
- `evt_first`  out  1  head is the first spike since reset; its `evt_isi` is the cycles since reset, saturated.
- `rate`  out  8  spikes counted in the last completed window, saturating at 255.
- `rate_valid`  out  1  one-cycle pulse when `rate` updates.
- `drop_cnt`  out  8  events lost to a full FIFO, saturating at 255.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Edge detect.** `spike_q` registers `(spike_in != 0)` every cycle regardless of `en`. A rising edge is `(spike_in != 0) && !spike_q && en`. A held spike produces exactly one edge.
- **ISI counter.** `isi_cnt` increments on each cycle with `en` high, saturating at all-ones. On an edge:
  - the event captures `{first_flag, isi_cnt}`;
  - `isi_cnt` loads 1;
  - `first_flag` clears.
- **Window.** `win_cnt` counts 0..WIN_CYC-1 while `en` is high and wraps. `acc` counts edges, saturating at 255. On the cycle where `win_cnt == WIN_CYC-1`:
  - `rate <= sat(acc + edge)`, so an edge on the last window cycle counts in the ending window;
  - `rate_valid` pulses;
  - `acc <= 0`.
- **FIFO.** First-word-fall-through; the head is visible on `evt_*` whenever `evt_valid` is high. Behaviour per case:
  - Push on edge.
  - Pop when `evt_valid && evt_ready`.
  - Full plus edge plus pop in the same cycle: push accepted, level unchanged.
  - Full plus edge with no pop: event dropped, `drop_cnt` increments.
  - Empty FIFO: `evt_ready` is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Enable low.** No edges, and `isi_cnt`, `win_cnt` and `acc` are frozen. The FIFO still drains. `spike_q` keeps tracking, so re-enabling during a held spike produces no edge.
- **Reset.** All of the following are cleared, effective immediately (asynchronous):
  - `evt_valid`=0, `rate`=0, `rate_valid`=0, `drop_cnt`=0, `fifo_level`=0;
  - `isi_cnt`=0, `win_cnt`=0, `acc`=0, `spike_q`=0;
  - `first_flag`=1.
  - An in-flight event held in the FIFO is discarded.
- **Output data.** `evt_isi` and `evt_first` are don't-care while `evt_valid` is low; the bench must not check them then.

## Timing
- An edge in cycle N gives `evt_valid` high in cycle N+1 if the FIFO was empty.
- A pop in cycle N presents the next head, or deasserts `evt_valid`, in cycle N+1.
- `rate` and `rate_valid` change at the posedge that ends the window's last cycle. `rate_valid` is high for exactly one cycle per window.
- `drop_cnt` and `fifo_level` update at the same posedge as the push or drop.
- All outputs are registered or derived directly from registers. There are no combinational paths from `spike_in` or `evt_ready` to any output.
- Throughput: one push and one pop per cycle.

## Structure
- The shared package `hh_pkg` holds:
  - the `TS_W` default;
  - `hh_evt_t` as a packed struct `{logic first; logic [TS_W-1:0] isi;}`;
  - the saturating-increment function, shared with the neuron core.
- The sub-module `hh_evt_fifo` is parameterised by depth and element type. It has push/full and pop/empty interfaces and an occupancy output.
- Edge detect, ISI counter, window, and drop counter live in the top module.

## Test plan
- **Basic ISI.** With `en`=1 and `evt_ready`=1, apply one-cycle spikes at cycles 10 and 14 after reset release. Expect:
  - event 1: `evt_first`=1, `evt_isi`=10, `evt_valid` high at cycle 11;
  - event 2: `evt_first`=0, `evt_isi`=4.
- **Held spike and enable.** Hold `spike_in`=8'h01 for 6 cycles. Expect exactly one event. Then deassert `en`, raise `spike_in`, reassert `en` while it is still high. Expect no event.
- **Overflow.** With `evt_ready`=0, apply 6 spikes. Expect `fifo_level`=4, `drop_cnt`=2, and the 4 oldest ISIs draining in order when `evt_ready` rises.
- **Full with simultaneous pop.** With the FIFO full, apply a spike in the same cycle as a pop. Expect `fifo_level` to stay at 4, `drop_cnt` unchanged, and the new event last in order.
- **Rate.** With `WIN_CYC`=16, apply 3 spikes, one of them on window cycle 15. Expect `rate`=3 with a one-cycle `rate_valid` pulse, and the next window, with no spikes, to report 0.
- **Reset mid-operation.** Assert `rst` with 2 events queued. Expect an immediate `evt_valid`=0, `fifo_level`=0, and `drop_cnt`=0; the first spike after release is flagged `evt_first`=1.
